rs_syndrome_gen: RTL and testbench
==================================

# rs_syndrome_gen

Parametrised Reed-Solomon syndrome generator for the CD decoder datapath. Consumes one GF(2^M) symbol per accepted beat, framed by a sync marker. Evaluates NSYN syndromes by Horner's rule and presents them as one registered, packed word with a valid pulse. Generalises the fixed 4-syndrome GF(256) front end to any field width, code length and syndrome count, and adds frame-error and stray-symbol reporting. It feeds the key-equation and inverse stages.

## Interface
- M, 8, symbol / field width in bits (3..8)
- POLY, 9'h11D, field generator polynomial, M+1 bits, bit M set
- N, 32, codeword length in symbols (2..2^M-1); 32 = CD C1, 28 = CD C2
- NSYN, 4, number of syndromes (1..8)
- FCR, 0, first consecutive root exponent; syndrome j uses root α^(FCR+j)
- i_clk  in  1  clock, all state on rising edge
- i_resb  in  1  reset, asynchronous, active-low
- i_data  in  M  received symbol, highest-degree coefficient first
- i_data_valid  in  1  symbol beat qualifier
- i_frame_sync  in  1  with i_data_valid, marks the first symbol of a codeword
- o_syn  out  NSYN*M  packed syndromes, S_j at bits [j*M +: M]
- o_syn_valid  out  1  one-cycle pulse, o_syn holds a new result
- o_nonzero  out  1  any S_j ≠ 0 for the current o_syn (error present)
- o_frame_err  out  1  one-cycle pulse, codeword aborted by early sync
- o_drop  out  1  one-cycle pulse, symbol discarded outside a frame

## Operation
- Reset (async, i_resb=0) sets: state IDLE, count 0, accumulators 0, o_syn 0, and all 1-bit outputs 0.
- Beat = cycle with i_data_valid=1. Cycles with i_data_valid=0 hold all state; i_data and i_frame_sync are ignored.
- IDLE:
  - beat with sync: acc_j ← i_data for all j, count ← 1, go to ACC.
  - beat without sync: symbol discarded, o_drop=1.
- ACC:
  - beat without sync: acc_j ← acc_j·α^(FCR+j) ⊕ i_data, count ← count+1.
  - Final-symbol beat (count = N-1 before the edge): the updated values load o_syn directly, o_syn_valid=1, o_nonzero = OR of the loaded values, count ← 0, go to IDLE.
  - beat with sync (early sync): o_frame_err=1, partial result discarded (o_syn unchanged, no o_syn_valid). The sync symbol starts a new frame: acc_j ← i_data, count ← 1, stay in ACC.
- Arithmetic:
  - GF(2^M) addition is XOR.
  - Multiplication by constant α^k is reduced modulo POLY; α = 2.
  - Exponents are taken mod 2^M-1.
- o_syn and o_nonzero hold until the next o_syn_valid or reset.
- count width is clog2(N+1).

## Timing
- Latency: o_syn/o_syn_valid are registered on the same edge that samples the N-th symbol. They are visible the following cycle.
- Throughput: one symbol per clock. Back-to-back codewords need no gap: a sync beat is accepted on the cycle directly after the final-symbol beat.
- At most one of o_syn_valid, o_frame_err, o_drop is high in any cycle.
- The per-symbol path is a single XOR plus constant multiplier per syndrome (no multi-cycle paths). It must close at the decoder clock for M=8.
- Reset mid-frame: the partial frame is lost and the next codeword needs a fresh sync. Reset deasserting has no effect until the next edge.

## Structure
- Shared package gf_pkg holds:
  - defaults for M and POLY (CD: 8, 9'h11D);
  - function gf_mul_alpha_pow(x, k, M, POLY), the constant multiply used at elaboration;
  - function clog2;
  - CD code constants N_C1=32 and N_C2=28.
- Sub-module gf_const_mul (parameters M, POLY, K) computes y = x·α^K combinationally. It is instantiated NSYN times with K = FCR+j.
- State is one register (IDLE/ACC), and count lives alongside it.

## Test plan
- All-zero codeword, defaults (N=32, NSYN=4): 32 beats of 0x00 with sync on the first → o_syn=0, o_nonzero=0, o_syn_valid pulses once, 1 cycle after the last beat.
- N=4, NSYN=2, FCR=0, M=8: symbols 0x00,0x00,0x00,0x01 → S0=0x01, S1=0x01, o_nonzero=1.
- Same config, symbols 0x01,0x00,0x00,0x00 → S0=0x01, S1=0x08 (α^3). Repeat with invalid gaps between beats → identical result.
- Early sync, defaults: sync, 10 beats, then sync + 31 beats of 0x00 → o_frame_err pulses on the second sync; one o_syn_valid with o_syn=0 after the 32nd symbol of the second frame.
- Stray symbols and back-to-back: 3 beats without sync in IDLE → 3 o_drop pulses. Then two consecutive 32-symbol frames with no gap → two o_syn_valid pulses 32 cycles apart.
- Reset mid-frame: assert i_resb=0 after 15 symbols → all outputs 0 immediately. Continuing beats without sync → o_drop until the next sync.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared GF(2^M) helpers and Reed-Solomon constants for the CD decoder datapath.
package gf_pkg;

  localparam int         GF_M_DEF    = 8;
  localparam logic [8:0] GF_POLY_DEF = 9'h11D;
  localparam int         N_C1        = 32;
  localparam int         N_C2        = 28;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } syn_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // x * alpha^k reduced modulo poly; k is folded into the multiplicative group order
  function automatic logic [7:0] gf_mul_alpha_pow(input logic [7:0] x, input int k,
                                                  input int m, input logic [8:0] poly);
    logic [8:0] v;
    int         e;
    e = k % ((1 << m) - 1);
    v = {1'b0, x};
    for (int i = 0; i < e; i++) begin
      v = {v[7:0], 1'b0};
      if (v[m]) v = v ^ poly;
      else      v = v;
    end
    return v[7:0];
  endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Combinational multiply by the constant alpha^K in GF(2^M); an XOR network fixed at elaboration.
module gf_const_mul
  import gf_pkg::*;
#(
  parameter int         M    = GF_M_DEF,
  parameter logic [M:0] POLY = (M+1)'(GF_POLY_DEF),
  parameter int         K    = 0
) (
  input  logic [M-1:0] i_x,
  output logic [M-1:0] o_y
);

  logic [M-1:0] col_s [M];

  for (genvar i = 0; i < M; i++) begin : g_col
    localparam logic [7:0] COL = gf_mul_alpha_pow(8'(1 << i), K, M, 9'(POLY));
    assign col_s[i] = COL[M-1:0];
  end

  // Product is the XOR of the alpha^K*2^i columns selected by the set bits of x
  always_comb begin
    o_y = '0;
    for (int i = 0; i < M; i++) begin
      if (i_x[i]) o_y = o_y ^ col_s[i];
      else        o_y = o_y;
    end
  end

endmodule

// File: rtl/rs_syndrome_gen.sv
// Reed-Solomon syndrome generator: Horner evaluation of NSYN syndromes over one framed codeword.
module rs_syndrome_gen
  import gf_pkg::*;
#(
  parameter int         M    = GF_M_DEF,
  parameter logic [M:0] POLY = (M+1)'(GF_POLY_DEF),
  parameter int         N    = N_C1,
  parameter int         NSYN = 4,
  parameter int         FCR  = 0
) (
  input  logic              i_clk,
  input  logic              i_resb,
  input  logic [M-1:0]      i_data,
  input  logic              i_data_valid,
  input  logic              i_frame_sync,
  output logic [NSYN*M-1:0] o_syn,
  output logic              o_syn_valid,
  output logic              o_nonzero,
  output logic              o_frame_err,
  output logic              o_drop
);

  localparam int CW = clog2(N + 1);

  syn_state_e        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [M-1:0]      acc_q [NSYN];
  logic [M-1:0]      acc_d [NSYN];
  logic [M-1:0]      acc_mul_s [NSYN];
  logic [NSYN*M-1:0] acc_next_s;
  logic [NSYN*M-1:0] syn_q, syn_d;
  logic              syn_valid_q, syn_valid_d;
  logic              nonzero_q, nonzero_d;
  logic              frame_err_q, frame_err_d;
  logic              drop_q, drop_d;
  logic              last_beat_s;

  for (genvar j = 0; j < NSYN; j++) begin : g_syn
    gf_const_mul #(.M(M), .POLY(POLY), .K(FCR + j)) u_mul (
      .i_x (acc_q[j]),
      .o_y (acc_mul_s[j])
    );
    assign acc_next_s[j*M +: M] = acc_mul_s[j] ^ i_data;
  end

  assign last_beat_s = (count_q == CW'(N - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: a sync beat always lands in ACC, the final symbol returns to IDLE
  always_comb begin
    state_d = state_q;
    if (i_data_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (i_frame_sync) state_d = ST_ACC;
          else              state_d = ST_IDLE;
        end
        ST_ACC: begin
          if (!i_frame_sync && last_beat_s) state_d = ST_IDLE;
          else                              state_d = ST_ACC;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and output pulses; an early sync drops the partial result and restarts
  always_comb begin
    count_d     = count_q;
    acc_d       = acc_q;
    syn_d       = syn_q;
    nonzero_d   = nonzero_q;
    syn_valid_d = 1'b0;
    frame_err_d = 1'b0;
    drop_d      = 1'b0;
    if (i_data_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (i_frame_sync) begin
            for (int j = 0; j < NSYN; j++) acc_d[j] = i_data;
            count_d = CW'(1);
          end else begin
            drop_d = 1'b1;
          end
        end
        ST_ACC: begin
          if (i_frame_sync) begin
            frame_err_d = 1'b1;
            for (int j = 0; j < NSYN; j++) acc_d[j] = i_data;
            count_d = CW'(1);
          end else if (last_beat_s) begin
            for (int j = 0; j < NSYN; j++) acc_d[j] = acc_next_s[j*M +: M];
            syn_d       = acc_next_s;
            nonzero_d   = |acc_next_s;
            syn_valid_d = 1'b1;
            count_d     = '0;
          end else begin
            for (int j = 0; j < NSYN; j++) acc_d[j] = acc_next_s[j*M +: M];
            count_d = count_q + CW'(1);
          end
        end
        default: begin
          count_d = '0;
        end
      endcase
    end else begin
      count_d = count_q;
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      count_q     <= '0;
      for (int j = 0; j < NSYN; j++) acc_q[j] <= '0;
      syn_q       <= '0;
      syn_valid_q <= 1'b0;
      nonzero_q   <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      acc_q       <= acc_d;
      syn_q       <= syn_d;
      syn_valid_q <= syn_valid_d;
      nonzero_q   <= nonzero_d;
      frame_err_q <= frame_err_d;
      drop_q      <= drop_d;
    end
  end

  assign o_syn       = syn_q;
  assign o_syn_valid = syn_valid_q;
  assign o_nonzero   = nonzero_q;
  assign o_frame_err = frame_err_q;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_rs_syndrome_gen.sv
// Directed bench: default CD C1 instance (a) plus a short N=4, NSYN=2 instance (b).
module tb_rs_syndrome_gen;

  logic        clk;
  logic        resb;
  logic [7:0]  a_data, b_data;
  logic        a_valid, a_sync, b_valid, b_sync;
  logic [31:0] a_syn;
  logic [15:0] b_syn;
  logic        a_sv, a_nz, a_fe, a_dr;
  logic        b_sv, b_nz, b_fe, b_dr;
  int          n_vec;
  int          n_err;

  rs_syndrome_gen dut_a (
    .i_clk(clk), .i_resb(resb), .i_data(a_data), .i_data_valid(a_valid),
    .i_frame_sync(a_sync), .o_syn(a_syn), .o_syn_valid(a_sv), .o_nonzero(a_nz),
    .o_frame_err(a_fe), .o_drop(a_dr)
  );

  rs_syndrome_gen #(.M(8), .POLY(9'h11D), .N(4), .NSYN(2), .FCR(0)) dut_b (
    .i_clk(clk), .i_resb(resb), .i_data(b_data), .i_data_valid(b_valid),
    .i_frame_sync(b_sync), .o_syn(b_syn), .o_syn_valid(b_sv), .o_nonzero(b_nz),
    .o_frame_err(b_fe), .o_drop(b_dr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_a(input logic [7:0] d, input logic s, input logic v);
    @(negedge clk);
    a_data = d; a_sync = s; a_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic [7:0] d, input logic s, input logic v);
    @(negedge clk);
    b_data = d; b_sync = s; b_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resb = 1'b1;
    #1 resb = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({a_syn, a_sv, a_nz, a_fe, a_dr} !== 36'h0) begin
      n_err++; $display("FAIL reset_a got %h want 0", {a_syn, a_sv, a_nz, a_fe, a_dr});
    end
    n_vec++;
    if ({b_syn, b_sv, b_nz, b_fe, b_dr} !== 20'h0) begin
      n_err++; $display("FAIL reset_b got %h want 0", {b_syn, b_sv, b_nz, b_fe, b_dr});
    end
    resb = 1'b1;
  endtask

  task automatic test_all_zero();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      step_a(8'h00, (i == 0), 1'b1);
      if (a_sv) pulses++;
    end
    n_vec++;
    if ({a_sv, a_syn, a_nz} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL all_zero got sv=%b syn=%h nz=%b want sv=1 syn=0 nz=0", a_sv, a_syn, a_nz);
    end
    step_a(8'h00, 1'b0, 1'b0);
    if (a_sv) pulses++;
    n_vec++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL all_zero_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_short_vectors();
    logic [7:0]  sym [4][4];
    logic [15:0] exp_syn [4];
    sym[0] = '{8'h00, 8'h00, 8'h00, 8'h01}; exp_syn[0] = 16'h0101;
    sym[1] = '{8'h01, 8'h00, 8'h00, 8'h00}; exp_syn[1] = 16'h0801;
    sym[2] = '{8'h02, 8'h00, 8'h00, 8'h80}; exp_syn[2] = 16'h9082;
    sym[3] = '{8'h80, 8'h00, 8'h00, 8'h00}; exp_syn[3] = 16'h7480;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 4; i++) step_b(sym[t][i], (i == 0), 1'b1);
      n_vec++;
      if ({b_sv, b_syn, b_nz} !== {1'b1, exp_syn[t], 1'b1}) begin
        n_err++; $display("FAIL short_vec%0d got sv=%b syn=%h nz=%b want sv=1 syn=%h nz=1",
                          t, b_sv, b_syn, b_nz, exp_syn[t]);
      end
    end
    // Same second vector with idle gaps carrying junk data and sync
    for (int i = 0; i < 4; i++) begin
      step_b(sym[1][i], (i == 0), 1'b1);
      if (i < 3) begin
        step_b(8'hFF, 1'b1, 1'b0);
        step_b(8'h5A, 1'b0, 1'b0);
      end
    end
    n_vec++;
    if ({b_sv, b_syn, b_nz, b_fe} !== {1'b1, 16'h0801, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL short_gaps got sv=%b syn=%h nz=%b fe=%b want sv=1 syn=0801 nz=1 fe=0",
                        b_sv, b_syn, b_nz, b_fe);
    end
    step_b(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_default_nonzero();
    for (int i = 0; i < 32; i++) step_a((i == 31) ? 8'h01 : 8'h00, (i == 0), 1'b1);
    n_vec++;
    if ({a_sv, a_syn, a_nz} !== {1'b1, 32'h01010101, 1'b1}) begin
      n_err++; $display("FAIL default_nonzero got sv=%b syn=%h nz=%b want sv=1 syn=01010101 nz=1",
                        a_sv, a_syn, a_nz);
    end
    step_a(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_early_sync();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      step_a(8'h33 + 8'(i), (i == 0), 1'b1);
      if (a_sv) pulses++;
    end
    step_a(8'h00, 1'b1, 1'b1);
    n_vec++;
    if ({a_fe, a_sv, a_syn, a_nz} !== {1'b1, 1'b0, 32'h01010101, 1'b1}) begin
      n_err++; $display("FAIL early_sync_abort got fe=%b sv=%b syn=%h nz=%b want fe=1 sv=0 syn=01010101 nz=1",
                        a_fe, a_sv, a_syn, a_nz);
    end
    for (int i = 0; i < 31; i++) begin
      step_a(8'h00, 1'b0, 1'b1);
      if (a_sv) pulses++;
    end
    n_vec++;
    if ({a_sv, a_syn, a_nz, a_fe} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL early_sync_result got sv=%b syn=%h nz=%b fe=%b want sv=1 syn=0 nz=0 fe=0",
                        a_sv, a_syn, a_nz, a_fe);
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL early_sync_pulses got %0d want 1", pulses);
    end
    step_a(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int drops, pulses, p0, p1;
    drops = 0; pulses = 0; p0 = -1; p1 = -1;
    for (int i = 0; i < 3; i++) begin
      step_a(8'hA5, 1'b0, 1'b1);
      if (a_dr && !a_sv && !a_fe) drops++;
    end
    n_vec++;
    if (drops !== 3) begin
      n_err++; $display("FAIL stray_drops got %0d want 3", drops);
    end
    for (int c = 0; c < 64; c++) begin
      step_a((c == 63) ? 8'h01 : 8'h00, ((c % 32) == 0), 1'b1);
      if (a_sv) begin
        pulses++;
        if (p0 < 0) begin
          p0 = c;
          n_vec++;
          if (a_syn !== 32'h0) begin
            n_err++; $display("FAIL b2b_first_syn got %h want 00000000", a_syn);
          end
        end else begin
          p1 = c;
        end
      end
      if (a_fe || a_dr) begin
        n_vec++; n_err++;
        $display("FAIL b2b_stray_pulse got fe=%b dr=%b at beat %0d want 0", a_fe, a_dr, c);
      end
    end
    n_vec++;
    if ({pulses, p0, p1} !== {32'd2, 32'd31, 32'd63}) begin
      n_err++; $display("FAIL b2b_pulses got n=%0d at %0d,%0d want n=2 at 31,63", pulses, p0, p1);
    end
    n_vec++;
    if ({a_syn, a_nz} !== {32'h01010101, 1'b1}) begin
      n_err++; $display("FAIL b2b_second_syn got syn=%h nz=%b want 01010101 nz=1", a_syn, a_nz);
    end
    step_a(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int drops;
    drops = 0;
    for (int i = 0; i < 15; i++) step_a(8'h11, (i == 0), 1'b1);
    #2 resb = 1'b0;
    #1;
    n_vec++;
    if ({a_syn, a_sv, a_nz, a_fe, a_dr} !== 36'h0) begin
      n_err++; $display("FAIL mid_reset_outputs got %h want 0", {a_syn, a_sv, a_nz, a_fe, a_dr});
    end
    @(negedge clk);
    resb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step_a(8'h22, 1'b0, 1'b1);
      if (a_dr) drops++;
    end
    n_vec++;
    if (drops !== 2) begin
      n_err++; $display("FAIL mid_reset_drops got %0d want 2", drops);
    end
    for (int i = 0; i < 32; i++) step_a((i == 31) ? 8'h01 : 8'h00, (i == 0), 1'b1);
    n_vec++;
    if ({a_sv, a_syn, a_nz} !== {1'b1, 32'h01010101, 1'b1}) begin
      n_err++; $display("FAIL mid_reset_refresh got sv=%b syn=%h nz=%b want sv=1 syn=01010101 nz=1",
                        a_sv, a_syn, a_nz);
    end
    step_a(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    a_data = 8'h00; a_valid = 1'b0; a_sync = 1'b0;
    b_data = 8'h00; b_valid = 1'b0; b_sync = 1'b0;
    test_reset();
    test_all_zero();
    test_short_vectors();
    test_default_nonzero();
    test_early_sync();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
